// File: rtl/peri_bus_pkg.sv
// Shared types and constants for the peripheral bus demultiplexer.
//   ERR_RDATA  : read data returned for unmapped accesses
//   IdxW       : width of the slave index field in the address
//   peri_txn_t : one outstanding transaction (target slave, error flag)
package peri_bus_pkg;

   localparam logic [31:0] ERR_RDATA = 32'hBADC_AB1E;
   localparam int          IdxW      = 4;

   typedef struct packed {
      logic [IdxW-1:0] idx;
      logic            err;
   } peri_txn_t;

endpackage

// File: rtl/peri_txn_fifo.sv
// In-order tracker for outstanding peripheral transactions.
//   clk, rst_n : clock, async active-low reset (flushes the FIFO)
//   push, din  : enqueue one entry (caller never pushes when full)
//   pop        : dequeue the head entry (caller never pops when empty)
//   full/empty : occupancy status
//   head       : oldest entry, valid while !empty
module peri_txn_fifo
   import peri_bus_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = peri_txn_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  T     din,
   input  logic pop,
   output logic full,
   output logic empty,
   output T     head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Index plus a wrap bit; the pointers are equal-indexed with opposite
   // wrap bits exactly when the FIFO is full. Index wraps at DEPTH so any
   // depth works, not only powers of two.
   logic [AW-1:0] wr_idx, rd_idx;
   logic          wr_wrap, rd_wrap;
   T              mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_idx  <= '0;
         wr_wrap <= 1'b0;
         rd_idx  <= '0;
         rd_wrap <= 1'b0;
      end else begin
         if (push) begin
            if (wr_idx == AW'(DEPTH - 1)) begin
               wr_idx  <= '0;
               wr_wrap <= ~wr_wrap;
            end else begin
               wr_idx <= wr_idx + AW'(1);
            end
         end
         if (pop) begin
            if (rd_idx == AW'(DEPTH - 1)) begin
               rd_idx  <= '0;
               rd_wrap <= ~rd_wrap;
            end else begin
               rd_idx <= rd_idx + AW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx] <= din;
      end
   end

   assign empty = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
   assign full  = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
   assign head  = mem[rd_idx];

endmodule

// File: rtl/peri_bus_demux.sv
// Peripheral bus demultiplexer: routes core peripheral-port requests to one
// of NSlv slaves by address, answers unmapped accesses internally with an
// error response, and returns all responses in grant order.
//   m_*         : core side (req/addr/write/be/wdata in; gnt/rvalid/rdata/err out)
//   s_req       : per-slave request; s_addr/write/be/wdata broadcast to all
//   s_gnt/s_rvalid/s_rdata : per-slave grant and response
//   proto_err_o : sticky, set by any slave response that was not expected
module peri_bus_demux
   import peri_bus_pkg::*;
#(
   parameter int          NSlv      = 4,
   parameter logic [31:0] PeriBase  = 32'h1A10_0000,
   parameter logic [31:0] PeriMask  = 32'h0000_FFFF,
   parameter int          RegionLsb = 12,
   parameter int          MaxOutst  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 m_req,
   input  logic [31:0]          m_addr,
   input  logic                 m_write,
   input  logic [3:0]           m_be,
   input  logic [31:0]          m_wdata,
   output logic                 m_gnt,
   output logic                 m_rvalid,
   output logic [31:0]          m_rdata,
   output logic                 m_err,
   output logic [NSlv-1:0]      s_req,
   output logic [31:0]          s_addr,
   output logic                 s_write,
   output logic [3:0]           s_be,
   output logic [31:0]          s_wdata,
   input  logic [NSlv-1:0]      s_gnt,
   input  logic [NSlv-1:0]      s_rvalid,
   input  logic [NSlv-1:0][31:0] s_rdata,
   output logic                 proto_err_o
);

   logic [IdxW-1:0] idx;
   logic            mapped;
   logic            full, empty;
   logic            req_ok;
   logic            sel_gnt;
   logic            head_rvalid;
   logic [31:0]     head_rdata;
   logic            stray;
   logic            err_pop;
   logic            push, pop;
   peri_txn_t       push_txn, head;

   assign idx    = m_addr[RegionLsb +: IdxW];
   assign mapped = ((m_addr & ~PeriMask) == PeriBase) && (32'(idx) < 32'(NSlv));

   // Gating with rst_n keeps grants and requests quiet while reset is held,
   // even though the request path itself is purely combinational.
   assign req_ok = rst_n & m_req & ~full;

   assign s_addr  = m_addr & PeriMask;
   assign s_write = m_write;
   assign s_be    = m_be;
   assign s_wdata = m_wdata;

   assign err_pop = ~empty & head.err;

   always_comb begin
      s_req       = '0;
      sel_gnt     = 1'b0;
      head_rvalid = 1'b0;
      head_rdata  = '0;
      stray       = 1'b0;
      for (int i = 0; i < NSlv; i++) begin
         if (idx == IdxW'(i)) begin
            s_req[i] = req_ok & mapped;
            sel_gnt  = s_gnt[i];
         end
         // Only the slave named by a mapped head may respond; anything else,
         // including a response while an error entry is at the head, is dropped.
         if (!empty && !head.err && head.idx == IdxW'(i)) begin
            head_rvalid = s_rvalid[i];
            head_rdata  = s_rdata[i];
         end else begin
            stray = stray | s_rvalid[i];
         end
      end
   end

   assign m_gnt = mapped ? (req_ok & sel_gnt) : req_ok;

   assign push         = m_gnt;
   assign push_txn.idx = idx;
   assign push_txn.err = ~mapped;
   assign pop          = err_pop | head_rvalid;

   assign m_rvalid = pop;
   assign m_err    = err_pop;
   assign m_rdata  = err_pop ? ERR_RDATA : (head_rvalid ? head_rdata : 32'h0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         proto_err_o <= 1'b0;
      end else if (stray) begin
         proto_err_o <= 1'b1;
      end
   end

   peri_txn_fifo #(
      .DEPTH (MaxOutst),
      .T     (peri_txn_t)
   ) u_txn_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_txn),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

endmodule

// File: tb/tb_peri_bus_demux.sv
module tb_peri_bus_demux;
   import peri_bus_pkg::*;

   localparam int          NSLV  = 4;
   localparam int          DEPTH = 2;
   localparam logic [31:0] BASE  = 32'h1A10_0000;
   localparam logic [31:0] MASK  = 32'h0000_FFFF;
   localparam logic [31:0] ERRD  = 32'hBADC_AB1E;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    m_req = 1'b0;
   logic [31:0]             m_addr = '0;
   logic                    m_write = 1'b0;
   logic [3:0]              m_be = 4'hF;
   logic [31:0]             m_wdata = '0;
   logic                    m_gnt, m_rvalid, m_err;
   logic [31:0]             m_rdata;
   logic [NSLV-1:0]         s_req;
   logic [31:0]             s_addr, s_wdata;
   logic                    s_write;
   logic [3:0]              s_be;
   logic [NSLV-1:0]         s_gnt = '0;
   logic [NSLV-1:0]         s_rvalid = '0;
   logic [NSLV-1:0][31:0]   s_rdata = '0;
   logic                    proto_err_o;

   always #5 clk = ~clk;

   peri_bus_demux #(
      .NSlv      (NSLV),
      .PeriBase  (BASE),
      .PeriMask  (MASK),
      .RegionLsb (12),
      .MaxOutst  (DEPTH)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m_req       (m_req),
      .m_addr      (m_addr),
      .m_write     (m_write),
      .m_be        (m_be),
      .m_wdata     (m_wdata),
      .m_gnt       (m_gnt),
      .m_rvalid    (m_rvalid),
      .m_rdata     (m_rdata),
      .m_err       (m_err),
      .s_req       (s_req),
      .s_addr      (s_addr),
      .s_write     (s_write),
      .s_be        (s_be),
      .s_wdata     (s_wdata),
      .s_gnt       (s_gnt),
      .s_rvalid    (s_rvalid),
      .s_rdata     (s_rdata),
      .proto_err_o (proto_err_o)
   );

   // Reference: the list of granted-but-unanswered transactions, oldest first.
   typedef struct {
      logic [3:0] idx;
      logic       err;
   } mtxn_t;

   mtxn_t q[$];
   logic  exp_proto = 1'b0;
   int    n_chk = 0;
   int    n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, derive the required outputs from the
   // address map and the in-order outstanding list, then advance the list.
   always @(negedge clk) begin
      logic [3:0]      a_idx;
      logic            mapped, full, gnt_e, rsp, rsp_err;
      logic [31:0]     rdata_e;
      logic [NSLV-1:0] sreq_e, hmask;
      if (!rst_n) begin
         chk("rst_gnt", 32'(m_gnt), 32'd0);
         chk("rst_sreq", 32'(s_req), 32'd0);
         chk("rst_rvalid", 32'(m_rvalid), 32'd0);
         chk("rst_rdata", m_rdata, 32'd0);
         chk("rst_err", 32'(m_err), 32'd0);
         chk("rst_proto", 32'(proto_err_o), 32'd0);
         q.delete();
         exp_proto = 1'b0;
      end else begin
         a_idx  = m_addr[15:12];
         mapped = ((m_addr & ~MASK) == BASE) && (a_idx < 4'(NSLV));
         full   = (q.size() >= DEPTH);
         gnt_e  = m_req && !full && (!mapped || s_gnt[a_idx[1:0]]);
         sreq_e = (m_req && mapped && !full) ? (NSLV'(1) << a_idx) : '0;
         hmask   = '0;
         rsp     = 1'b0;
         rsp_err = 1'b0;
         rdata_e = '0;
         if (q.size() > 0) begin
            if (q[0].err) begin
               rsp     = 1'b1;
               rsp_err = 1'b1;
               rdata_e = ERRD;
            end else begin
               hmask = NSLV'(1) << q[0].idx;
               if (s_rvalid[q[0].idx[1:0]]) begin
                  rsp     = 1'b1;
                  rdata_e = s_rdata[q[0].idx[1:0]];
               end
            end
         end
         chk("m_gnt", 32'(m_gnt), 32'(gnt_e));
         chk("s_req", 32'(s_req), 32'(sreq_e));
         chk("m_rvalid", 32'(m_rvalid), 32'(rsp));
         chk("proto_err", 32'(proto_err_o), 32'(exp_proto));
         if (rsp) begin
            chk("m_rdata", m_rdata, rdata_e);
            chk("m_err", 32'(m_err), 32'(rsp_err));
         end
         if (sreq_e != '0) begin
            chk("s_addr", s_addr, m_addr & MASK);
            chk("s_write", 32'(s_write), 32'(m_write));
            chk("s_be", 32'(s_be), 32'(m_be));
            chk("s_wdata", s_wdata, m_wdata);
         end
         if ((s_rvalid & ~hmask) != '0) exp_proto = 1'b1;
         if (rsp) void'(q.pop_front());
         if (gnt_e) q.push_back('{idx: a_idx, err: !mapped});
      end
   end

   // One bus cycle: inputs change 1 time unit after the rising edge and
   // default to idle; the caller overrides what it needs.
   task automatic tick();
      @(posedge clk);
      #1;
      m_req    = 1'b0;
      m_write  = 1'b0;
      m_be     = 4'hF;
      m_wdata  = $urandom;
      s_gnt    = '0;
      s_rvalid = '0;
      for (int i = 0; i < NSLV; i++) s_rdata[i] = $urandom;
   endtask

   task automatic look();
      @(negedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic w);
      m_req   = 1'b1;
      m_addr  = a;
      m_write = w;
   endtask

   initial begin
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Mapped read to slave 1, response two cycles later
      tick(); req(32'h1A10_1004, 1'b0); s_gnt = 4'b0010;
      look(); chk("t1_gnt", 32'(m_gnt), 32'd1);
              chk("t1_sreq", 32'(s_req), 32'h2);
              chk("t1_saddr", s_addr, 32'h0000_1004);
      tick();
      tick();
      tick(); s_rvalid = 4'b0010; s_rdata[1] = 32'h1234_5678;
      look(); chk("t1_rvalid", 32'(m_rvalid), 32'd1);
              chk("t1_rdata", m_rdata, 32'h1234_5678);
              chk("t1_err", 32'(m_err), 32'd0);

      // Unmapped write (slave index 9), error response next cycle
      tick(); req(32'h1A10_9000, 1'b1); s_gnt = 4'hF;
      look(); chk("t2_gnt", 32'(m_gnt), 32'd1);
              chk("t2_sreq", 32'(s_req), 32'd0);
              chk("t2_rvalid_now", 32'(m_rvalid), 32'd0);
      tick();
      look(); chk("t2_rvalid", 32'(m_rvalid), 32'd1);
              chk("t2_err", 32'(m_err), 32'd1);
              chk("t2_rdata", m_rdata, ERRD);

      // Slave 2 responds out of order: dropped and flagged
      tick(); req(32'h1A10_0000, 1'b0); s_gnt = 4'hF;
      tick(); req(32'h1A10_2000, 1'b0); s_gnt = 4'hF;
      tick(); s_rvalid = 4'b0100;
      look(); chk("t3_drop", 32'(m_rvalid), 32'd0);
      tick(); s_rvalid = 4'b0001; s_rdata[0] = 32'hCAFE_0000;
      look(); chk("t3_rvalid", 32'(m_rvalid), 32'd1);
              chk("t3_rdata", m_rdata, 32'hCAFE_0000);
              chk("t3_proto", 32'(proto_err_o), 32'd1);
      tick(); s_rvalid = 4'b0100; s_rdata[2] = 32'h2222_0002;
      look(); chk("t3_rdata2", m_rdata, 32'h2222_0002);

      // Third request stalls while two are outstanding
      tick(); req(32'h1A10_0010, 1'b0); s_gnt = 4'hF;
      look(); chk("t4_gnt_a", 32'(m_gnt), 32'd1);
      tick(); req(32'h1A10_1010, 1'b0); s_gnt = 4'hF;
      look(); chk("t4_gnt_b", 32'(m_gnt), 32'd1);
      for (int k = 0; k < 4; k++) begin
         tick(); req(32'h1A10_2010, 1'b0); s_gnt = 4'hF;
         look(); chk("t4_gnt_held", 32'(m_gnt), 32'd0);
      end
      tick(); req(32'h1A10_2010, 1'b0); s_gnt = 4'hF; s_rvalid = 4'b0001;
      look(); chk("t4_pop", 32'(m_rvalid), 32'd1);
              chk("t4_gnt_popcycle", 32'(m_gnt), 32'd0);
      tick(); req(32'h1A10_2010, 1'b0); s_gnt = 4'hF;
      look(); chk("t4_gnt_c", 32'(m_gnt), 32'd1);
      tick(); s_rvalid = 4'b0010;
      tick(); s_rvalid = 4'b0100;
      look(); chk("t4_last", 32'(m_rvalid), 32'd1);

      // Outside-window read followed by mapped read to slave 3
      tick(); req(32'h2000_0000, 1'b0); s_gnt = 4'hF;
      look(); chk("t5_gnt_err", 32'(m_gnt), 32'd1);
              chk("t5_sreq_err", 32'(s_req), 32'd0);
      tick(); req(32'h1A10_3000, 1'b0); s_gnt = 4'b1000;
      look(); chk("t5_gnt_s3", 32'(m_gnt), 32'd1);
              chk("t5_err_first", 32'(m_err & m_rvalid), 32'd1);
      tick();
      tick(); s_rvalid = 4'b1000; s_rdata[3] = 32'h3333_0003;
      look(); chk("t5_s3_rvalid", 32'(m_rvalid), 32'd1);
              chk("t5_s3_rdata", m_rdata, 32'h3333_0003);
              chk("t5_s3_err", 32'(m_err), 32'd0);

      // Reset with two outstanding; late response after release
      tick(); req(32'h1A10_0000, 1'b0); s_gnt = 4'hF;
      tick(); req(32'h1A10_1000, 1'b0); s_gnt = 4'hF;
      tick(); rst_n = 1'b0; req(32'h1A10_0000, 1'b0); s_gnt = 4'hF;
      look(); chk("t6_gnt", 32'(m_gnt), 32'd0);
              chk("t6_sreq", 32'(s_req), 32'd0);
              chk("t6_proto", 32'(proto_err_o), 32'd0);
      tick(); rst_n = 1'b1;
      tick(); s_rvalid = 4'b0001;
      look(); chk("t6_no_rvalid", 32'(m_rvalid), 32'd0);
      tick();
      look(); chk("t6_proto_set", 32'(proto_err_o), 32'd1);

      // Randomized traffic against the reference list
      tick(); rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst_n   = ($urandom_range(0, 599) != 0);
         m_req   = 1'($urandom_range(0, 1));
         m_write = 1'($urandom_range(0, 1));
         m_be    = 4'($urandom);
         s_gnt   = NSLV'($urandom);
         case ($urandom_range(0, 5))
            0, 1, 2: m_addr = BASE | (32'($urandom_range(0, 3)) << 12) | ($urandom & 32'hFFC);
            3:       m_addr = BASE | (32'($urandom_range(4, 15)) << 12) | ($urandom & 32'hFFC);
            4:       m_addr = BASE + 32'h0001_0000 + ($urandom & 32'hFFFF);
            default: m_addr = $urandom;
         endcase
         if (q.size() > 0 && !q[0].err && $urandom_range(0, 2) == 0)
            s_rvalid[q[0].idx[1:0]] = 1'b1;
         if ($urandom_range(0, 199) == 0)
            s_rvalid[$urandom_range(0, NSLV - 1)] = 1'b1;
      end
      tick();
      rst_n = 1'b1;
      look();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
